// File: rtl/sram_arbiter_pkg.sv
// sram_arb_pkg: shared types and the round-robin pick helper for sram_arbiter.
package sram_arb_pkg;
  typedef enum logic [0:0] {ARB, LOCKED} arb_state_t;
  localparam int MAX_REQ = 8;
  // Unused valid bits above NUM_REQ are zero, so wrapping modulo MAX_REQ equals wrapping modulo NUM_REQ.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr);
    logic [MAX_REQ-1:0] g;
    logic [2:0] idx;
    g = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (valid[idx]) g = MAX_REQ'(1) << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/sram_arbiter_rr.sv
// rr_arbiter: combinational one-hot round-robin pick starting at ptr_i.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);
  assign grant_o = N'(rr_pick(MAX_REQ'(valid_i), 3'(ptr_i)));
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin, lockable arbiter in front of a single-port 1-cycle-read SRAM.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            mem_cs,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_din,
  input  logic [DATA_WIDTH-1:0]           mem_dout
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  arb_state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, rd_id_q, rd_id_d, w;
  logic rd_pend_q, rd_pend_d, acc;
  logic [NUM_REQ-1:0] pick;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .valid_i(req_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(pick)
  );
  assign req_ready = rst ? '0 : (state_q == LOCKED) ? NUM_REQ'(1) << owner_q : pick;
  assign acc = |(req_ready & req_valid);
  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) w = IW'(i);
  end
  assign mem_cs    = acc;
  assign mem_we    = acc & req_we[w];
  assign mem_addr  = acc ? req_addr[w*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_din   = acc ? req_wdata[w*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rd_pend_d = acc & ~req_we[w];
  assign rd_id_d   = w;
  // A response from before a reset must not leak out during it.
  assign rsp_valid = (rd_pend_q & ~rst) ? NUM_REQ'(1) << rd_id_q : '0;
  assign rsp_rdata = (rd_pend_q & ~rst) ? mem_dout : '0;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == ARB) begin
      if (acc) begin
        rr_ptr_d = nxt(w);
        state_d  = req_lock[w] ? LOCKED : ARB;
        owner_d  = req_lock[w] ? w : owner_q;
      end
    end else if (!req_lock[owner_q]) begin
      state_d  = ARB;
      rr_ptr_d = nxt(owner_q);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a write-first 1-cycle SRAM model.
module tb_sram_arbiter;
  typedef struct {
    logic [1:0] oh;
    logic [7:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0, req_ready, req_we = '0, req_lock = '0, rsp_valid;
  logic [7:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0] rsp_rdata, mem_din, mem_dout = '0;
  logic mem_cs, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] sram [16];
  logic [7:0] ref_mem [16];
  exp_t exp_q[$];
  int n_chk = 0, n_err = 0;

  sram_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs & mem_we) sram[mem_addr] <= mem_din;
    if (mem_cs & !mem_we) mem_dout <= sram[mem_addr];
  end

  function automatic logic [7:0] pre(input int i);
    return 8'(8'h30 + i * 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] acc;
    int k;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      check("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp", {rsp_valid, rsp_rdata}, {e.oh, e.d});
      end else check("no_rsp", {rsp_valid, rsp_rdata}, 0);
      acc = req_valid & req_ready;
      check("mem_cs", mem_cs, acc != 0);
      if (acc != 0) begin
        k = acc[1] ? 1 : 0;
        check("mem_addr", mem_addr, req_addr[k*4 +: 4]);
        check("mem_we", mem_we, req_we[k]);
        if (req_we[k]) ref_mem[req_addr[k*4 +: 4]] = req_wdata[k*8 +: 8];
        else exp_q.push_back('{oh: acc, d: ref_mem[req_addr[k*4 +: 4]]});
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [3:0] a0, input logic [3:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic cyc(input string tag, input logic [1:0] rdy, input logic cs);
    @(negedge clk);
    check(tag, req_ready, rdy);
    check({tag, "_cs"}, mem_cs, cs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rsp(input string tag, input logic [9:0] e);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    check(tag, {rsp_valid, rsp_rdata}, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i]    = pre(i);
      ref_mem[i] = pre(i);
    end
    drive(2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
    cyc("rst_ready", 2'b00, 1'b0);
    cyc("rst_ready", 2'b00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc("rr_both", (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
    idle_rsp("rr_last_rsp", {2'b10, pre(2)});
    drive(2'b01, 2'b00, 2'b00, 3, 0, 0, 0);
    cyc("single_rd", 2'b01, 1'b1);
    idle_rsp("single_rsp", {2'b01, pre(3)});
    drive(2'b10, 2'b10, 2'b00, 0, 7, 0, 8'hA5);
    cyc("wr_req1", 2'b10, 1'b1);
    drive(2'b01, 2'b00, 2'b00, 7, 0, 0, 0);
    cyc("rd_after_wr", 2'b01, 1'b1);
    idle_rsp("wr_rd_rsp", {2'b01, 8'hA5});
    drive(2'b10, 2'b00, 2'b00, 0, 5, 0, 0);
    cyc("pre_lock_rd", 2'b10, 1'b1);
    idle_rsp("pre_lock_rsp", {2'b10, pre(5)});
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b01, (i < 3) ? 2'b01 : 2'b00, 4'(i), 5, 8'(8'h50 + i), 0);
      cyc("lock_burst", 2'b01, 1'b1);
    end
    drive(2'b10, 2'b00, 2'b00, 0, 5, 0, 0);
    cyc("after_unlock", 2'b10, 1'b1);
    idle_rsp("after_unlock_rsp", {2'b10, pre(5)});
    drive(2'b01, 2'b00, 2'b00, 4, 0, 0, 0);
    cyc("rd_before_rst", 2'b01, 1'b1);
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 6, 8, 0, 0);
    cyc("rst_mid", 2'b00, 1'b0);
    rst = 1'b0;
    cyc("post_rst_0", 2'b01, 1'b1);
    cyc("post_rst_1", 2'b10, 1'b1);
    idle_rsp("post_rst_rsp", {2'b10, pre(8)});
    drive(2'b11, 2'b00, 2'b01, 2, 5, 0, 0);
    cyc("lock_rd", 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 2'b00, 2'b11, 0, 5, 0, 0);
      cyc("owner_idle", 2'b01, 1'b0);
    end
    drive(2'b10, 2'b00, 2'b00, 0, 5, 0, 0);
    cyc("unlock_idle", 2'b01, 1'b0);
    cyc("req1_granted", 2'b10, 1'b1);
    idle_rsp("final_rsp", {2'b10, pre(5)});
    check("lock_wr_data", ref_mem[2], 8'h52);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares one single-port `sram` (1-cycle registered read) among `NUM_REQ` requesters, e.g. the token/vocab lookup path and the tensor-core operand loader. Each requester drives a valid/ready command channel and receives a tagged read response. A per-requester lock gives uninterrupted bursts. Sits directly in front of the `sram` instance and drives its `cs`/`we`/`addr`/`din`.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 8: SRAM word width.
- `ADDR_WIDTH`, 4: SRAM address width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  command valid, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant; command accepted when `req_valid[i] & req_ready[i]`.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_lock`  in  NUM_REQ  keep ownership after this transfer.
- `req_addr`  in  NUM_REQ×ADDR_WIDTH  packed, requester i at slice i.
- `req_wdata`  in  NUM_REQ×DATA_WIDTH  packed write data.
- `rsp_valid`  out  NUM_REQ  one-hot read-data strobe, no backpressure.
- `rsp_rdata`  out  DATA_WIDTH  read data, valid only with `rsp_valid`.
- `mem_cs`, `mem_we`  out  1  SRAM chip select / write enable.
- `mem_addr`  out  ADDR_WIDTH; `mem_din`  out  DATA_WIDTH; `mem_dout`  in  DATA_WIDTH.

## Operation
- FSM `ARB` / `LOCKED`, reset to `ARB`.
- `ARB`: winner is the first valid requester at or after `rr_ptr`, wrapping modulo NUM_REQ. `req_ready` is combinational, one-hot for the winner, all-zero if no `req_valid`.
- On accept: `mem_cs=1`, `mem_we=req_we[w]`, `mem_addr`/`mem_din` = winner's slices, same cycle, combinationally. `rr_ptr <= (w+1) mod NUM_REQ`.
- Accept with `req_lock[w]=1`: go to `LOCKED`, store `owner=w`.
- `LOCKED`: `req_ready` = one-hot `owner` only; other requesters are stalled. The owner may drop `req_valid` and still keeps ownership.
  - Exit to `ARB` on the first cycle `req_lock[owner]=0`. A transfer accepted in that cycle is still issued.
  - `rr_ptr` is frozen while `LOCKED` and set to `owner+1` on exit.
- No accept: `mem_cs=0`, `mem_we=0`, `mem_addr`/`mem_din` = 0.
- Reads: register `rd_pend<=1`, `rd_id<=w`. Next cycle `rsp_valid[rd_id]=1` and `rsp_rdata=mem_dout`.
- Writes produce no response.
- Back-to-back reads, including from different requesters, sustain 1 per cycle.
- Write then read to the same address on consecutive cycles returns the new data; the SRAM is write-first/ordered.

## Timing
- Reset state: `rr_ptr=0`, state `ARB`, `rd_pend=0`.
  - `rsp_valid=0` and `rsp_rdata=0`: `rsp_rdata` is gated to 0 when `rsp_valid` is 0.
  - `req_ready=0` and all `mem_*` outputs = 0 while `rst` is high.
- Read latency: accept at edge N, `rsp_valid` high during cycle N+1, exactly one cycle.
- Throughput: one command per cycle.
- Reset mid-burst or with a read pending: the response is dropped (`rsp_valid=0` the following cycle), `LOCKED` returns to `ARB`, pointer returns to 0.
- Simultaneous valid on all requesters: strict rotation 0,1,…,NUM_REQ-1,0.
- `req_lock` from a non-owner while `LOCKED` is ignored.
- Address wrap is not handled here; the requester owns its address range.

## Structure
- Package `sram_arb_pkg`:
  - `arb_state_t` enum {`ARB`, `LOCKED`}.
  - `MAX_REQ=8`.
  - Function `rr_pick(valid, ptr)` returning a one-hot result.
- Sub-module `rr_arbiter`: combinational round-robin one-hot pick from `req_valid` and `rr_ptr`, instantiated once.
- Top holds the FSM, `rr_ptr`, `owner`, and the `rd_pend`/`rd_id` registers.

## Test plan
Bench: `NUM_REQ=2`, `DATA_WIDTH=8`, `ADDR_WIDTH=4`, `sram` instance attached, preload with `vocab.bin`.
- Single read, req0 addr 3, no contention → `req_ready=01` same cycle, `rsp_valid=01` next cycle, `rsp_rdata` = file word 3.
- Both valid reads held for 4 cycles (req0 addr 1, req1 addr 2) → grants 01,10,01,10; responses alternate, tagged one cycle later.
- req1 writes 0xA5 to addr 7, then req0 reads addr 7 next cycle → `rsp_rdata=A5`.
- req0 asserts lock and writes addr 0..3 while req1 is valid continuously → req1 `ready=0` for all 4 cycles. req0 drops lock on the last write; req1 is granted the following cycle.
- Read accepted, `rst` pulsed high next cycle → no `rsp_valid`, `req_ready=0` during reset. First post-reset contention is granted to req0.
- Locked owner idles 3 cycles with `req_valid=0` → `mem_cs=0`, other requester still stalled until lock drops.
